// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch controller: FSM encoding,
// AXI response code, the instruction-side ARPROT value and a state helper.
package fetch_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_AR       = 3'd1;
  localparam logic [2:0] ST_R        = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_DRAIN_AR = 3'd4;
  localparam logic [2:0] ST_DRAIN_R  = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] ARPROT_INST   = 3'b100;

  // True for states in which a bus transaction is in flight.
  function automatic logic state_busy(input logic [2:0] st);
    return (st == ST_AR) || (st == ST_R) || (st == ST_DRAIN_AR) || (st == ST_DRAIN_R);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// AXI-Lite read address / read data channels of the instruction-side port.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Two free-running 32-bit event counters (fetches completed, stall cycles);
// they wrap naturally at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [1:0] inc;
  assign inc = {stall_inc_i, fetch_inc_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_q;
      logic [31:0] cnt_d;

      always_comb cnt_d = cnt_q + 32'(inc[gi]);

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign fetch_cnt_o = g_cnt[0].cnt_q;
  assign stall_cnt_o = g_cnt[1].cnt_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one single-beat AXI-Lite read per PC value,
// with flush draining. Define FETCH_PERF_CNT_EN to add performance counters.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter logic [2:0] ARPROT_VAL = ARPROT_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  inst_fetch_ctrl_if.master axi
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [2:0]        state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              bus_err_q, bus_err_d;

  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    araddr_d     = araddr_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    bus_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ce_i && !flush_i) begin
          araddr_d  = pc_i;
          arvalid_d = 1'b1;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        // A flush cannot retract arvalid; the handshake completes and the reply is drained.
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = flush_i ? ST_DRAIN_R : ST_R;
        end else if (flush_i) begin
          state_d = ST_DRAIN_AR;
        end
      end
      ST_R: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          state_d  = ST_IDLE;
          if (!flush_i) begin
            state_d      = ST_HOLD;
            inst_valid_d = 1'b1;
            if (axi.rresp == AXI_RESP_OKAY) begin
              inst_d = axi.rdata;
            end else begin
              inst_d    = '0;
              bus_err_d = 1'b1;
            end
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN_R;
        end
      end
      ST_HOLD: begin
        if (flush_i || !hold_i) begin
          inst_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      ST_DRAIN_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DRAIN_R;
        end
      end
      ST_DRAIN_R: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stallreq_o   = (state_q == ST_IDLE) ? ce_i : state_busy(state_q);
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign bus_err_o    = bus_err_q;

  assign axi.araddr  = araddr_q;
  assign axi.arprot  = ARPROT_VAL;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

`ifdef FETCH_PERF_CNT_EN
  logic fetch_done;
  assign fetch_done = (state_q == ST_R) && axi.rvalid && !flush_i;

  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (fetch_done),
    .stall_inc_i (stallreq_o),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized bench for inst_fetch_ctrl: a transaction-level fetch model and a
// randomly timed AXI-Lite slave, with directed phases for latency/hold/flush/error.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i, hold_i, flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o, stallreq_o, bus_err_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o),
    .bus_err_o    (bus_err_o),
    .axi          (bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Stimulus knobs (percentages / fixed values / slave latencies; delay < 0 means random).
  bit          rst_k = 1'b1;
  int unsigned p_rst = 0, p_ce = 0, p_hold = 0, p_flush = 0, p_err = 0;
  bit          pc_fix_en = 1'b1, data_fix_en = 1'b1;
  logic [31:0] pc_fix = 32'h0, data_fix = 32'h0;
  int          ar_delay = 0, rv_delay = 0;

  // Reference model: a fetch is either requested-not-accepted, awaiting data,
  // possibly condemned by a flush, or completed and presented to IF/ID.
  bit          m_busy = 0, m_ar_pending = 0, m_doomed = 0, m_holding = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_inst = 0;
  int unsigned m_fetch_cnt = 0, m_stall_cnt = 0;

  // Slave bookkeeping.
  bit          s_pending = 0, s_rvalid = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  s_rresp = 0;
  int          ar_cnt = 0, rv_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic one_cycle();
    bit exp_stall, exp_rready;
    @(negedge clk);
    cyc++;
    rst     = rst_k || ($urandom_range(99) < p_rst);
    ce_i    = ($urandom_range(99) < p_ce);
    pc_i    = pc_fix_en ? pc_fix : ($urandom & 32'hFFFF_FFFC);
    hold_i  = ($urandom_range(99) < p_hold);
    flush_i = ($urandom_range(99) < p_flush);
    if (ar_delay >= 0) bus.arready = (ar_cnt >= ar_delay);
    else               bus.arready = ($urandom_range(99) < 50);
    if (s_pending && !s_rvalid) begin
      if ((rv_delay >= 0) ? (rv_cnt >= rv_delay) : ($urandom_range(99) < 50)) begin
        s_rvalid = 1'b1;
        s_rdata  = data_fix_en ? data_fix : $urandom;
        s_rresp  = ($urandom_range(99) < p_err) ? 2'($urandom_range(3, 1)) : 2'b00;
      end
    end
    bus.rvalid = s_rvalid;
    bus.rdata  = s_rvalid ? s_rdata : $urandom;
    bus.rresp  = s_rvalid ? s_rresp : 2'($urandom_range(3));
    #1;

    exp_stall  = m_busy || (!m_holding && ce_i);
    exp_rready = m_busy && !m_ar_pending;
    check("arvalid",    32'(bus.arvalid),   32'(m_ar_pending));
    check("araddr",     bus.araddr,         m_addr);
    check("arprot",     32'(bus.arprot),    32'h4);
    check("rready",     32'(bus.rready),    32'(exp_rready));
    check("inst",       inst_o,             m_inst);
    check("inst_valid", 32'(inst_valid_o),  32'(m_holding));
    check("bus_err",    32'(bus_err_o),     32'(m_err));
    check("stallreq",   32'(stallreq_o),    32'(exp_stall));
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
    check("perf_stall", perf_stall_cnt, m_stall_cnt);
`endif

    // Slave reacts to handshakes seen at the coming edge.
    if (rst) begin
      s_pending = 0; s_rvalid = 0; ar_cnt = 0; rv_cnt = 0;
    end else if (m_ar_pending && bus.arready) begin
      s_pending = 1; ar_cnt = 0; rv_cnt = 0;
    end else if (m_ar_pending) begin
      ar_cnt++;
    end else if (s_rvalid && exp_rready) begin
      s_pending = 0; s_rvalid = 0;
    end else if (s_pending && !s_rvalid) begin
      rv_cnt++;
    end

    // Model advances one edge.
    if (rst) begin
      m_busy = 0; m_ar_pending = 0; m_doomed = 0; m_holding = 0; m_err = 0;
      m_addr = 0; m_inst = 0; m_fetch_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (exp_stall) m_stall_cnt++;
      m_err = 0;
      if (m_holding) begin
        if (flush_i || !hold_i) m_holding = 0;
      end else if (!m_busy) begin
        if (ce_i && !flush_i) begin
          m_busy = 1; m_ar_pending = 1; m_addr = pc_i; m_doomed = 0;
        end
      end else if (m_ar_pending) begin
        if (bus.arready) m_ar_pending = 0;
        if (flush_i) m_doomed = 1;
      end else if (bus.rvalid) begin
        m_busy = 0;
        if (!(m_doomed || flush_i)) begin
          m_holding = 1;
          m_fetch_cnt++;
          if (bus.rresp == 2'b00) m_inst = bus.rdata;
          else begin m_inst = 0; m_err = 1; end
        end
      end else if (flush_i) begin
        m_doomed = 1;
      end
    end
  endtask

  initial begin
    int lat, n_err;
    logic [31:0] first_inst;
    rst = 1'b1; ce_i = 0; hold_i = 0; flush_i = 0; pc_i = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;

    repeat (3) one_cycle();
    rst_k = 0;

    // Zero-wait fetch from PC 0: latency to inst_valid_o.
    p_ce = 100; pc_fix = 32'h0; data_fix = 32'h2401_0001;
    lat = -1; first_inst = 0;
    for (int i = 0; i < 8; i++) begin
      one_cycle();
      if (inst_valid_o && lat < 0) begin lat = i; first_inst = inst_o; end
    end
    check("fetch_latency", 32'(lat), 32'd3);
    check("first_inst", first_inst, 32'h2401_0001);

    // Slow arready, araddr must stay put.
    pc_fix = 32'h4; ar_delay = 5;
    repeat (20) one_cycle();

    // Hold the presented word for 4 cycles.
    ar_delay = 0;
    for (int i = 0; i < 20 && !m_holding; i++) one_cycle();
    check("hold_reached", 32'(m_holding), 32'd1);
    p_hold = 100; repeat (4) one_cycle();
    p_hold = 0;   repeat (8) one_cycle();

    // Flush while the address phase is stalled.
    ar_delay = 3; pc_fix = 32'h8;
    for (int i = 0; i < 20 && !m_ar_pending; i++) one_cycle();
    check("ar_reached", 32'(m_ar_pending), 32'd1);
    p_flush = 100; one_cycle();
    p_flush = 0; pc_fix = 32'hC;
    repeat (16) one_cycle();

    // Error response presented and held: exactly one bus_err pulse.
    ar_delay = 0; rv_delay = 1; p_err = 100; data_fix = 32'hDEAD_BEEF; p_hold = 100;
    for (int i = 0; i < 20 && !(m_holding || m_busy); i++) one_cycle();
    n_err = 0;
    for (int i = 0; i < 12; i++) begin
      one_cycle();
      if (bus_err_o) n_err++;
    end
    check("bus_err_pulses", 32'(n_err), 32'd1);
    check("err_inst", inst_o, 32'h0);
    p_hold = 0; p_err = 0;

    // Three zero-wait fetches from reset.
    rv_delay = 0; data_fix = 32'h1234_5678;
    rst_k = 1; one_cycle(); rst_k = 0;
    p_ce = 100; repeat (12) one_cycle();
    p_ce = 0;   repeat (3) one_cycle();
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_3", perf_fetch_cnt, 32'd3);
    check("perf_stall_9", perf_stall_cnt, 32'd9);
`endif

    // Random traffic.
    ar_delay = -1; rv_delay = -1; pc_fix_en = 0; data_fix_en = 0;
    p_ce = 80; p_hold = 30; p_flush = 8; p_err = 15; p_rst = 1;
    repeat (3000) one_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Sequences instruction fetch between the PC register and the AXI-Lite instruction-side read port.
- Takes the current pc/ce, issues one single-beat AXI-Lite read per PC value, buffers the returned word and presents it to the IF/ID stage.
- Raises a stall request to the pipeline controller while a fetch is outstanding.
- Handles pipeline flush with a legal drain of any in-flight transaction.

Parameters:
- ADDR_W, 32, width of pc and araddr.
- DATA_W, 32, instruction/rdata width.
- ARPROT_VAL, 3'b100, constant driven on arprot (instruction, secure, unprivileged).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pc_i  in  ADDR_W  current PC.
- ce_i  in  1  PC chip enable; no fetch while low.
- hold_i  in  1  IF stage held by pipeline (stall[1]); fetched word must persist.
- flush_i  in  1  pipeline flush; current fetch is discarded.
- inst_o  out  DATA_W  fetched instruction.
- inst_valid_o  out  1  inst_o valid for pc_i.
- stallreq_o  out  1  stall request to pipeline controller.
- bus_err_o  out  1  one-cycle pulse on non-OKAY rresp.
- araddr  out  ADDR_W  AR address.
- arprot  out  3  constant ARPROT_VAL.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  DATA_W  read data.
- rresp  in  2  read response.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, arvalid=0, rready=0, araddr=0, inst_o=0, inst_valid_o=0, bus_err_o=0. Reset mid-transaction abandons it; the slave is reset by the same rst.
- FSM states: IDLE, AR, R, HOLD, DRAIN_AR, DRAIN_R.
- IDLE: if ce_i && !flush_i, register araddr<=pc_i, arvalid<=1, go to AR. Otherwise stay.
- AR: arvalid stays high with araddr stable until arready. On arready: arvalid<=0, rready<=1, go to R. flush_i here goes to DRAIN_AR, because arvalid is never dropped before the handshake.
- R: on rvalid: rready<=0 and go to HOLD.
  - If rresp==2'b00: inst_o<=rdata.
  - Otherwise: inst_o<=0 (NOP) and bus_err_o pulses for 1 cycle.
  - In both cases inst_valid_o<=1.
  - flush_i without rvalid goes to DRAIN_R.
  - flush_i together with rvalid: data is dropped, go to IDLE.
- HOLD: inst_o and inst_valid_o are stable.
  - !hold_i: the pipeline consumes the word this edge (PC advances this edge); inst_valid_o<=0, go to IDLE.
  - flush_i: inst_valid_o<=0, go to IDLE. flush has priority over hold_i.
- DRAIN_AR: keep arvalid until arready, then rready<=1, go to DRAIN_R.
- DRAIN_R: on rvalid: discard the data, rready<=0, go to IDLE. No bus_err_o pulse is raised for discarded responses.
- stallreq_o (combinational) = 1 in AR, R, DRAIN_AR and DRAIN_R, and in IDLE when ce_i=1; 0 in HOLD and when ce_i=0.
- Latency with zero-wait slave: IDLE→AR (1), AR→R (1), R→HOLD (1). inst_valid_o rises 3 cycles after the IDLE cycle; issue rate is 1 instruction per 4 cycles.
- Exactly one outstanding transaction at any time. araddr is never changed while arvalid=1.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on each R→HOLD transition.
  - perf_stall_cnt increments on each cycle with stallreq_o=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: FSM state encoding (3-bit localparams), AXI_RESP_OKAY=2'b00, ARPROT_INST=3'b100.
- Sub-module fetch_perf_cnt (two saturating-free 32-bit counters), instantiated only under FETCH_PERF_CNT_EN.
- FSM and datapath stay flat in inst_fetch_ctrl.

Test Plan:
- Reset, then ce_i=1, pc_i=0x0, slave with arready and rvalid immediate, rdata=0x24010001 → arvalid at cycle 1, inst_o=0x24010001 and inst_valid_o=1 at cycle 3, stallreq_o low only in HOLD.
- arready delayed 5 cycles with pc_i=0x4 → araddr stays 0x4 and arvalid stays high until the handshake; stallreq_o is high throughout.
- hold_i=1 for 4 cycles in HOLD → inst_o unchanged, no new arvalid; next fetch issues 1 cycle after hold_i falls.
- flush_i pulsed in the AR state with arready delayed 3 cycles → arvalid held until the handshake, the response is drained, inst_valid_o never rises, next fetch uses the new pc_i.
- rresp=2'b10 with rdata=0xDEADBEEF → inst_o=0, inst_valid_o=1, bus_err_o high for exactly 1 cycle.
- With FETCH_PERF_CNT_EN, 3 zero-wait fetches with hold_i=0 → perf_fetch_cnt=3; perf_stall_cnt=9 (3 stall cycles per fetch).
